// File: rtl/pip_ma_lsu_if.sv
// Data-memory request/ack bus between the MA stage (master) and data memory (slave).
interface pip_ma_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              oMemREQ;
    logic              oMemWE;
    logic [ADDR_W-1:0] oMemADDR;
    logic [3:0]        oMemBE;
    logic [31:0]       oMemWDATA;
    logic              iMemACK;
    logic [31:0]       iMemRDATA;

    modport master (output oMemREQ, oMemWE, oMemADDR, oMemBE, oMemWDATA,
                    input  iMemACK, iMemRDATA);
    modport slave  (input  oMemREQ, oMemWE, oMemADDR, oMemBE, oMemWDATA,
                    output iMemACK, iMemRDATA);
endinterface

// File: rtl/pip_ma_lsu.sv
// RV32I Memory Access stage: ALU passthrough, load/store over a req/ack bus, timeout watchdog.
// Optional MA_MISALIGN_TRAP_EN: misaligned H/W accesses pulse oMisalign instead of touching the bus.
module pip_ma_lsu #(
    parameter int ADDR_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iValid,
    input  logic                  iMEM,
    input  logic                  iRW,
    input  logic [4:0]            iDecodedOP,
    input  logic [ADDR_W-1:0]     iAddr,
    input  logic [31:0]           iStoreDATA,
    input  logic [REG_ADDR_W-1:0] iDregADDR,
    input  logic [31:0]           iDregDATA,
    output logic                  oStall,
    output logic [REG_ADDR_W-1:0] oDregADDR,
    output logic [31:0]           oDregDATA,
    output logic                  oDregWE,
    output logic                  oBusErr,
    output logic                  oMisalign,
    pip_ma_lsu_if.master          mem
);
    // Opcode values mirror DecodedOP.vh
    localparam logic [4:0] OP_LB = 5'd11, OP_LH = 5'd12, OP_LW = 5'd13, OP_LBU = 5'd14;
    localparam logic [4:0] OP_LHU = 5'd15, OP_SB = 5'd16, OP_SH = 5'd17, OP_SW = 5'd18;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;

    logic [REG_ADDR_W-1:0] dreg_addr_q, dreg_addr_d, rd_q, rd_d;
    logic [31:0]           dreg_data_q, dreg_data_d, wdata_q, wdata_d;
    logic                  dreg_we_q, dreg_we_d, req_q, req_d, mwe_q, mwe_d;
    logic [ADDR_W-1:0]     maddr_q, maddr_d;
    logic [3:0]            be_q, be_d;
    logic [1:0]            lane_q, lane_d;
    logic                  isb_q, isb_d, ish_q, ish_d, sgn_q, sgn_d;
    logic                  bus_err_q, bus_err_d, misalign_q, misalign_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic        is_b, is_h, sgn, misal, timeout;
    logic [3:0]  be_n;
    logic [31:0] wdata_n, rd_shift, ld_data;
    logic [15:0] ld_half;

    // Width comes from the opcode; anything unrecognised falls back to a full word.
    assign is_b = (iDecodedOP == OP_LB) || (iDecodedOP == OP_LBU) || (iDecodedOP == OP_SB);
    assign is_h = (iDecodedOP == OP_LH) || (iDecodedOP == OP_LHU) || (iDecodedOP == OP_SH);
    assign sgn  = (iDecodedOP == OP_LB) || (iDecodedOP == OP_LH);
    assign be_n = is_b ? (4'b0001 << iAddr[1:0]) : is_h ? (iAddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_n = is_b ? {4{iStoreDATA[7:0]}} : is_h ? {2{iStoreDATA[15:0]}} : iStoreDATA;

`ifdef MA_MISALIGN_TRAP_EN
    assign misal = (is_h && iAddr[0]) || (!is_b && !is_h && (iAddr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    assign rd_shift = mem.iMemRDATA >> {lane_q, 3'b000};
    assign ld_half  = lane_q[1] ? mem.iMemRDATA[31:16] : mem.iMemRDATA[15:0];
    assign ld_data  = isb_q ? {{24{sgn_q & rd_shift[7]}}, rd_shift[7:0]} :
                      ish_q ? {{16{sgn_q & ld_half[15]}}, ld_half} : mem.iMemRDATA;

    assign timeout = (state_q == BUSY) && !mem.iMemACK && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;     dreg_addr_q <= '0;   dreg_data_q <= '0;   dreg_we_q <= 1'b0;
            req_q <= 1'b0;       mwe_q <= 1'b0;       maddr_q <= '0;       be_q <= '0;
            wdata_q <= '0;       rd_q <= '0;          lane_q <= '0;        isb_q <= 1'b0;
            ish_q <= 1'b0;       sgn_q <= 1'b0;       bus_err_q <= 1'b0;   misalign_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;  dreg_addr_q <= dreg_addr_d; dreg_data_q <= dreg_data_d;
            dreg_we_q <= dreg_we_d; req_q <= req_d;   mwe_q <= mwe_d;      maddr_q <= maddr_d;
            be_q <= be_d;        wdata_q <= wdata_d;  rd_q <= rd_d;        lane_q <= lane_d;
            isb_q <= isb_d;      ish_q <= ish_d;      sgn_q <= sgn_d;      bus_err_q <= bus_err_d;
            misalign_q <= misalign_d; cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (iValid && iMEM && !misal) state_d = BUSY;
            BUSY: if (mem.iMemACK || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dreg_addr_d = dreg_addr_q; dreg_data_d = dreg_data_q; dreg_we_d = dreg_we_q;
        req_d = req_q; mwe_d = mwe_q; maddr_d = maddr_q; be_d = be_q; wdata_d = wdata_q;
        rd_d = rd_q; lane_d = lane_q; isb_d = isb_q; ish_d = ish_q; sgn_d = sgn_q;
        bus_err_d = 1'b0; misalign_d = 1'b0; cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                dreg_we_d = 1'b0;
                if (iValid && !iMEM) begin
                    dreg_addr_d = iDregADDR;
                    dreg_data_d = iDregDATA;
                    dreg_we_d   = 1'b1;
                end else if (iValid && misal) begin
                    misalign_d = 1'b1;
                end else if (iValid) begin
                    req_d   = 1'b1;
                    mwe_d   = !iRW;
                    maddr_d = {iAddr[ADDR_W-1:2], 2'b00};
                    be_d    = be_n;
                    wdata_d = wdata_n;
                    rd_d    = iDregADDR;
                    lane_d  = iAddr[1:0];
                    isb_d   = is_b;
                    ish_d   = is_h;
                    sgn_d   = sgn;
                end
            end
            BUSY: begin
                dreg_we_d = 1'b0;
                cnt_d     = cnt_q + CNT_W'(1);
                if (mem.iMemACK) begin
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    dreg_we_d = 1'b1;
                    // Stores retire as a write to x0 so WB sees a uniform completion
                    if (mwe_q) dreg_addr_d = '0;
                    else begin
                        dreg_addr_d = rd_q;
                        dreg_data_d = ld_data;
                    end
                end else if (timeout) begin
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign oStall = !iRST && ((state_q == IDLE) ? (iValid && iMEM && !misal)
                                                : (!mem.iMemACK && !timeout));
    assign oDregADDR     = dreg_addr_q;
    assign oDregDATA     = dreg_data_q;
    assign oDregWE       = dreg_we_q;
    assign oBusErr       = bus_err_q;
    assign oMisalign     = misalign_q;
    assign mem.oMemREQ   = req_q;
    assign mem.oMemWE    = mwe_q;
    assign mem.oMemADDR  = maddr_q;
    assign mem.oMemBE    = be_q;
    assign mem.oMemWDATA = wdata_q;
endmodule

// File: tb/tb_pip_ma_lsu.sv
// Directed bench for pip_ma_lsu with TIMEOUT_CYC=4; expected values are hand-computed.
module tb_pip_ma_lsu;
    localparam logic [4:0] OP_LB = 5'd11, OP_LH = 5'd12, OP_LW = 5'd13, OP_LBU = 5'd14;
    localparam logic [4:0] OP_LHU = 5'd15, OP_SB = 5'd16, OP_SH = 5'd17, OP_SW = 5'd18;

    logic        iCLK = 1'b0, iRST = 1'b1;
    logic        iValid = 0, iMEM = 0, iRW = 0;
    logic [4:0]  iDecodedOP = '0;
    logic [31:0] iAddr = '0, iStoreDATA = '0, iDregDATA = '0;
    logic [4:0]  iDregADDR = '0;
    logic        oStall, oDregWE, oBusErr, oMisalign;
    logic [4:0]  oDregADDR;
    logic [31:0] oDregDATA;
    int          n_chk = 0, n_pass = 0;

    pip_ma_lsu_if #(.ADDR_W(32)) mem ();

    pip_ma_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT_CYC(4)) dut (
        .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iMEM(iMEM), .iRW(iRW),
        .iDecodedOP(iDecodedOP), .iAddr(iAddr), .iStoreDATA(iStoreDATA),
        .iDregADDR(iDregADDR), .iDregDATA(iDregDATA), .oStall(oStall),
        .oDregADDR(oDregADDR), .oDregDATA(oDregDATA), .oDregWE(oDregWE),
        .oBusErr(oBusErr), .oMisalign(oMisalign), .mem(mem));

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic rw, input logic [31:0] a,
                         input logic [31:0] st, input logic [4:0] rd);
        iValid = 1; iMEM = 1; iRW = rw; iDecodedOP = op; iAddr = a; iStoreDATA = st; iDregADDR = rd;
        #1;
    endtask

    task automatic idle_in();
        iValid = 0; iMEM = 0;
    endtask

    initial begin
        int n;
        mem.iMemACK = 0; mem.iMemRDATA = '0;
        step(); step();
        chk("rst_we", oDregWE, 0);
        chk("rst_req", mem.oMemREQ, 0);
        chk("rst_data", oDregDATA, 0);
        chk("rst_buserr", oBusErr, 0);
        iRST = 0;
        step();

        // ALU passthrough
        iValid = 1; iMEM = 0; iDregADDR = 5; iDregDATA = 32'hDEADBEEF; #1;
        chk("alu_stall", oStall, 0);
        step(); idle_in();
        chk("alu_addr", oDregADDR, 5);
        chk("alu_data", oDregDATA, 32'hDEADBEEF);
        chk("alu_we", oDregWE, 1);
        step();
        chk("bubble_we", oDregWE, 0);
        chk("bubble_hold", oDregDATA, 32'hDEADBEEF);

        // LB 0x103, ack in first BUSY cycle
        issue(OP_LB, 1, 32'h103, 0, 7);
        chk("lb_acc_stall", oStall, 1);
        step(); idle_in();
        chk("lb_req", mem.oMemREQ, 1);
        chk("lb_we", mem.oMemWE, 0);
        chk("lb_addr", mem.oMemADDR, 32'h100);
        chk("lb_be", mem.oMemBE, 4'b1000);
        mem.iMemACK = 1; mem.iMemRDATA = 32'h80FF_FF00; #1;
        chk("lb_ack_stall", oStall, 0);
        step(); mem.iMemACK = 0;
        chk("lb_req_drop", mem.oMemREQ, 0);
        chk("lb_data", oDregDATA, 32'hFFFFFF80);
        chk("lb_rd", oDregADDR, 7);
        chk("lb_dwe", oDregWE, 1);
        step();

        // LHU 0x102, ack after 3 wait cycles (ack coincides with the timeout count: ack wins)
        issue(OP_LHU, 1, 32'h102, 0, 3);
        step(); idle_in();
        chk("lhu_be", mem.oMemBE, 4'b1100);
        n = 0;
        while (mem.oMemREQ && n < 10) begin
            n++;
            if (n == 4) begin mem.iMemACK = 1; mem.iMemRDATA = 32'h8001_1234; end
            else if (n < 4) begin #1; chk("lhu_wait_stall", oStall, 1); end
            step();
        end
        mem.iMemACK = 0;
        chk("lhu_req_cycles", n, 4);
        chk("lhu_data", oDregDATA, 32'h00008001);
        chk("lhu_buserr", oBusErr, 0);
        step();

        // LH sign extension, low half
        issue(OP_LH, 1, 32'h100, 0, 4);
        step(); idle_in();
        mem.iMemACK = 1; mem.iMemRDATA = 32'h0000_8001;
        step(); mem.iMemACK = 0;
        chk("lh_data", oDregDATA, 32'hFFFF8001);
        step();

        // SB 0x101
        issue(OP_SB, 0, 32'h101, 32'h000000AB, 9);
        step(); idle_in();
        chk("sb_we", mem.oMemWE, 1);
        chk("sb_be", mem.oMemBE, 4'b0010);
        chk("sb_wdata", mem.oMemWDATA, 32'hABABABAB);
        mem.iMemACK = 1;
        step(); mem.iMemACK = 0;
        chk("sb_rd", oDregADDR, 0);
        chk("sb_dwe", oDregWE, 1);
        step();

        // SH 0x102
        issue(OP_SH, 0, 32'h102, 32'h0000BEEF, 1);
        step(); idle_in();
        chk("sh_be", mem.oMemBE, 4'b1100);
        chk("sh_wdata", mem.oMemWDATA, 32'hBEEFBEEF);
        mem.iMemACK = 1;
        step(); mem.iMemACK = 0;
        step();

        // Timeout with no ack
        issue(OP_LW, 1, 32'h200, 0, 6);
        step(); idle_in();
        n = 0;
        while (mem.oMemREQ && n < 10) begin
            n++;
            if (n == 4) chk("to_final_stall", oStall, 0);
            step();
        end
        chk("to_busy_cycles", n, 4);
        chk("to_buserr", oBusErr, 1);
        chk("to_dwe", oDregWE, 0);
        mem.iMemACK = 1;   // stray ack in IDLE
        step(); mem.iMemACK = 0;
        chk("to_buserr_pulse", oBusErr, 0);
        chk("idle_ack_ignored", oDregWE, 0);
        step();

        // Reset mid-BUSY, then a late ack
        issue(OP_LW, 1, 32'h300, 0, 8);
        step(); idle_in();
        step();
        chk("rstb_req", mem.oMemREQ, 1);
        iRST = 1;
        step(); iRST = 0;
        chk("rstb_req_drop", mem.oMemREQ, 0);
        mem.iMemACK = 1;
        step(); mem.iMemACK = 0;
        chk("rstb_late_ack", oDregWE, 0);
        chk("rstb_req_idle", mem.oMemREQ, 0);
        step();

        // LW at 0x102
        issue(OP_LW, 1, 32'h102, 0, 2);
`ifdef MA_MISALIGN_TRAP_EN
        chk("mis_stall", oStall, 0);
        step(); idle_in();
        chk("mis_pulse", oMisalign, 1);
        chk("mis_req", mem.oMemREQ, 0);
        chk("mis_dwe", oDregWE, 0);
        step();
        chk("mis_pulse_end", oMisalign, 0);
        chk("mis_req_after", mem.oMemREQ, 0);
`else
        chk("lw_stall", oStall, 1);
        step(); idle_in();
        chk("lw_req", mem.oMemREQ, 1);
        chk("lw_addr", mem.oMemADDR, 32'h100);
        chk("lw_be", mem.oMemBE, 4'b1111);
        chk("lw_misalign", oMisalign, 0);
        mem.iMemACK = 1; mem.iMemRDATA = 32'h12345678;
        step(); mem.iMemACK = 0;
        chk("lw_data", oDregDATA, 32'h12345678);
        chk("lw_rd", oDregADDR, 2);
`endif
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
